// File: rtl/present_dec_if.sv
// Handshake and data bundle between a host and the PRESENT-80 decryption core.
// The host drives start/data_in/key and the core returns dout/busy/done.
interface present_dec_if;
    logic        start;
    logic [0:63] data_in;
    logic [0:79] key;
    logic [0:63] dout;
    logic        busy;
    logic        done;

    modport master (output start, data_in, key, input dout, busy, done);
    modport slave  (input start, data_in, key, output dout, busy, done);
endinterface

// File: rtl/present_dec_core.sv
// Iterative PRESENT-80 decryption core, one inverse round per clock, MSB-first bit numbering.
// Define PRESENT_DEC_KEYEXP_EN to accept the original key and expand it on chip to K32.
module present_dec_core (
    input  logic         clk,
    input  logic         rst_n,
    present_dec_if.slave bus
);
`ifdef PRESENT_DEC_KEYEXP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, KEXP = 2'd1, ROUND = 2'd2} fsm_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd2} fsm_e;
`endif

    fsm_e        fsm_q;
    logic [0:63] state_q;
    logic [0:79] key_q;
    logic [4:0]  cnt_q;
    logic [0:63] dout_q;
    logic        busy_q;
    logic        done_q;
    logic [0:79] round_key_d;
    logic [0:63] round_state_d;
`ifdef PRESENT_DEC_KEYEXP_EN
    logic [0:79] fwd_key_d;
`endif

    function automatic logic [0:3] sbox4(input logic [0:3] x);
        logic [0:3] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [0:3] inv_sbox4(input logic [0:3] x);
        logic [0:3] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Encryption sends bit j to 16*j mod 63, so bit j of the result is picked from there.
    function automatic logic [0:63] inv_player(input logic [0:63] s);
        logic [0:63] r;
        for (int j = 0; j < 63; j++) begin
            r[j] = s[(16 * j) % 63];
        end
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [0:63] inv_slayer(input logic [0:63] s);
        logic [0:63] r;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = inv_sbox4(s[4*n +: 4]);
        end
        return r;
    endfunction

    // k19..k15 live at indices 60..64; k79..k76 at indices 0..3.
    function automatic logic [0:79] key_inv(input logic [0:79] k, input logic [4:0] i);
        logic [0:79] t;
        t        = k;
        t[60:64] = t[60:64] ^ i;
        t[0:3]   = inv_sbox4(t[0:3]);
        return {t[19:79], t[0:18]};
    endfunction

`ifdef PRESENT_DEC_KEYEXP_EN
    function automatic logic [0:79] key_fwd(input logic [0:79] k, input logic [4:0] i);
        logic [0:79] t;
        t        = {k[61:79], k[0:60]};
        t[0:3]   = sbox4(t[0:3]);
        t[60:64] = t[60:64] ^ i;
        return t;
    endfunction
`endif

    // Round datapath: previous round key and the state after one inverse round.
    always_comb begin
        round_key_d   = key_inv(key_q, cnt_q);
        round_state_d = inv_slayer(inv_player(state_q)) ^ round_key_d[0:63];
`ifdef PRESENT_DEC_KEYEXP_EN
        fwd_key_d     = key_fwd(key_q, cnt_q);
`endif
    end

    // Control FSM with all state and outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= 64'h0;
            key_q   <= 80'h0;
            cnt_q   <= 5'd0;
            dout_q  <= 64'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        key_q  <= bus.key;
`ifdef PRESENT_DEC_KEYEXP_EN
                        state_q <= bus.data_in;
                        cnt_q   <= 5'd1;
                        fsm_q   <= KEXP;
`else
                        state_q <= bus.data_in ^ bus.key[0:63];
                        cnt_q   <= 5'd31;
                        fsm_q   <= ROUND;
`endif
                    end
                end
`ifdef PRESENT_DEC_KEYEXP_EN
                KEXP: begin
                    key_q <= fwd_key_d;
                    if (cnt_q == 5'd31) begin
                        state_q <= state_q ^ fwd_key_d[0:63];
                        cnt_q   <= 5'd31;
                        fsm_q   <= ROUND;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
`endif
                ROUND: begin
                    state_q <= round_state_d;
                    key_q   <= round_key_d;
                    cnt_q   <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        dout_q <= round_state_d;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        fsm_q  <= IDLE;
                    end
                end
                default: begin
                    fsm_q  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_present_dec_core.sv
// Self-checking bench for present_dec_core: known-answer vectors, back-to-back,
// ignored start, mid-operation reset and random blocks against a PRESENT-80 encryption model.
module tb_present_dec_core;
`ifdef PRESENT_DEC_KEYEXP_EN
    localparam int LAT         = 63;
    localparam int ABORT_TICKS = 40;
`else
    localparam int LAT         = 32;
    localparam int ABORT_TICKS = 9;
`endif

    typedef logic [63:0] rk_t [1:32];
    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] ra, rb, rc;
    logic [63:0] pt, ct;
    logic [79:0] kk;
    bit          seen;

    present_dec_if bus ();

    present_dec_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Standard PRESENT-80 key schedule in LSB-first numbering: round keys 1..32 and K32.
    function automatic void sched(input logic [79:0] k, output rk_t rk, output logic [79:0] k32);
        logic [79:0] t;
        logic [4:0]  ii;
        t = k;
        for (int i = 1; i <= 31; i++) begin
            rk[i]      = t[79:16];
            t          = {t[18:0], t[79:19]};
            t[79:76]   = SBOX[t[79:76]];
            ii         = i[4:0];
            t[19:15]   = t[19:15] ^ ii;
        end
        rk[32] = t[79:16];
        k32    = t;
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] p, input logic [79:0] k);
        rk_t         rk;
        logic [79:0] k32;
        logic [63:0] s, q;
        sched(k, rk, k32);
        s = p;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
            for (int b = 0; b < 64; b++) q[(b == 63) ? 63 : (16 * b) % 63] = s[b];
            s = q;
        end
        return s ^ rk[32];
    endfunction

    function automatic logic [79:0] key_port(input logic [79:0] k);
`ifdef PRESENT_DEC_KEYEXP_EN
        return k;
`else
        rk_t         rk;
        logic [79:0] k32;
        sched(k, rk, k32);
        return k32;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [63:0] c, input logic [79:0] k);
        bus.data_in = c;
        bus.key     = key_port(k);
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    // Entered in cycle T+1; leaves the bench in the done cycle (or after the cycle budget).
    task automatic wait_done(input logic [63:0] exp, input string tag, input bit poke);
        int k       = 1;
        bit busy_ok = 1'b1;
        while (bus.done !== 1'b1 && k < LAT + 8) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (poke && k == 5) begin
                bus.start   = 1'b1;
                bus.data_in = ~bus.data_in;
                bus.key     = ~bus.key;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            k++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'(LAT));
        check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_busy_clear"}, 64'(bus.busy), 64'd0);
        check({tag, "_dout"}, bus.dout, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = 64'h0;
        bus.key     = 80'h0;
        tick();
        tick();
        check("rst_dout", bus.dout, 64'h0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        tick();

        launch(64'h5579C1387B228445, 80'h0);
        wait_done(64'h0, "v1", 1'b0);
        tick();
        check("v1_pulse", 64'(bus.done), 64'd0);
        check("v1_hold", bus.dout, 64'h0);

        launch(64'hE72C46C0F5945049, {80{1'b1}});
        wait_done(64'h0, "v2_ignored_start", 1'b1);
        tick();

        launch(64'hA112FFC72F68417B, 80'h0);
        wait_done({64{1'b1}}, "v3", 1'b0);
        bus.data_in = 64'h3333DCD3213210D2;
        bus.key     = key_port({80{1'b1}});
        bus.start   = 1'b1;
        check("v3_readable", bus.dout, {64{1'b1}});
        tick();
        bus.start = 1'b0;
        check("v4_busy_after_b2b", 64'(bus.busy), 64'd1);
        wait_done({64{1'b1}}, "v4_b2b", 1'b0);
        tick();

        launch(64'h5579C1387B228445, 80'h0);
        repeat (ABORT_TICKS) tick();
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_dout", bus.dout, 64'h0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        seen = 1'b0;
        repeat (LAT + 5) begin
            tick();
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        launch(64'hA112FFC72F68417B, 80'h0);
        wait_done({64{1'b1}}, "after_abort", 1'b0);
        tick();

        for (int r = 0; r < 4; r++) begin
            ra = $urandom; rb = $urandom; rc = $urandom;
            pt = {ra, rb};
            ra = $urandom;
            kk = {rc[15:0], ra, rb ^ rc};
            ct = encrypt(pt, kk);
            launch(ct, kk);
            wait_done(pt, $sformatf("rand%0d", r), 1'b0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
